// File: rtl/lsu_mem_ctrl_if.sv
// Request/response channel between the MEM stage and the LSU, and the
// word-wide data-memory port driven by the LSU.

interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: splits misaligned accesses into two word accesses, forms
// byte lanes for stores, merges and extends load data, and aborts on timeout.

module lsu_mem_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [1:0]  off_reg;
    logic [31:0] base_reg;
    logic [31:0] wdata_reg;
    logic [31:0] lo_reg;
    logic [31:0] hi_reg;
    logic        err_reg;
    logic [7:0]  wait_cnt_reg;

    logic        accept;
    logic        in_acc;
    logic        ack_hit;
    logic        wait_hit;
    logic        split;
    logic [2:0]  nbytes;
    logic [3:0]  byte_keep;
    logic [31:0] wdata_masked;
    logic [63:0] wide;
    logic [7:0]  msk;
    logic [63:0] cat;
    logic [7:0]  lane_byte [4];
    logic        sign_bit;
    logic [7:0]  fill;
    logic [31:0] load_res;

    assign accept   = (state_reg == IDLE) && req.req_valid;
    assign in_acc   = (state_reg == ACC0) || (state_reg == ACC1);
    assign ack_hit  = in_acc && mem.mem_ack;
    // an ack in the final wait cycle still counts as a normal completion
    assign wait_hit = in_acc && !mem.mem_ack && (wait_cnt_reg == 8'(MAX_WAIT - 1));

    always_comb begin
        case (size_reg)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign split = ({1'b0, off_reg} + nbytes) > 3'd4;
    assign cat   = {hi_reg, lo_reg};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [2:0] lane;
            assign byte_keep[gi]           = 3'(gi) < nbytes;
            assign wdata_masked[8*gi +: 8] = byte_keep[gi] ? wdata_reg[8*gi +: 8] : 8'h00;
            assign lane                    = {1'b0, off_reg} + 3'(gi);
            assign lane_byte[gi]           = cat[{lane, 3'b000} +: 8];
            assign load_res[8*gi +: 8]     = byte_keep[gi] ? lane_byte[gi] : fill;
        end
    endgenerate

    assign wide     = {32'h0, wdata_masked} << {off_reg, 3'b000};
    assign msk      = {4'b0000, byte_keep} << off_reg;
    assign sign_bit = (size_reg == 2'b00) ? lane_byte[0][7] : lane_byte[1][7];
    assign fill     = uns_reg ? 8'h00 : {8{sign_bit}};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req.req_valid)
                    state_next = (req.req_size == 2'b11) ? RESP : ACC0;
            end
            ACC0: begin
                if (mem.mem_ack)
                    state_next = split ? ACC1 : RESP;
                else if (wait_hit)
                    state_next = RESP;
            end
            ACC1: begin
                if (mem.mem_ack || wait_hit)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            uns_reg      <= 1'b0;
            off_reg      <= 2'b00;
            base_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            lo_reg       <= 32'h0;
            hi_reg       <= 32'h0;
            err_reg      <= 1'b0;
            wait_cnt_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg    <= req.req_we;
                size_reg  <= req.req_size;
                uns_reg   <= req.req_unsigned;
                off_reg   <= req.req_addr[1:0];
                base_reg  <= {req.req_addr[31:2], 2'b00};
                wdata_reg <= req.req_wdata;
                lo_reg    <= 32'h0;
                hi_reg    <= 32'h0;
                err_reg   <= (req.req_size == 2'b11);
            end
            if (ack_hit && state_reg == ACC0)
                lo_reg <= mem.mem_rdata;
            if (ack_hit && state_reg == ACC1)
                hi_reg <= mem.mem_rdata;
            if (wait_hit)
                err_reg <= 1'b1;
            if (state_next != state_reg && (state_next == ACC0 || state_next == ACC1))
                wait_cnt_reg <= 8'h00;
            else if (in_acc && !mem.mem_ack)
                wait_cnt_reg <= wait_cnt_reg + 8'h01;
        end
    end

    always_comb begin
        mem.mem_req   = in_acc;
        mem.mem_addr  = 32'h0;
        mem.mem_we    = 4'b0000;
        mem.mem_wdata = 32'h0;
        if (state_reg == ACC0) begin
            mem.mem_addr = base_reg;
            if (we_reg) begin
                mem.mem_we    = msk[3:0];
                mem.mem_wdata = wide[31:0];
            end
        end else if (state_reg == ACC1) begin
            mem.mem_addr = base_reg + 32'd4;
            if (we_reg) begin
                mem.mem_we    = msk[7:4];
                mem.mem_wdata = wide[63:32];
            end
        end
    end

    assign req.req_ready = (state_reg == IDLE);
    assign req.busy      = (state_reg != IDLE);
    assign req.rsp_valid = (state_reg == RESP);
    assign req.rsp_err   = (state_reg == RESP) && err_reg;
    assign req.rsp_rdata = ((state_reg == RESP) && !we_reg && !err_reg) ? load_res : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: vector table plus scoreboard queues for memory
// accesses and responses, and hand-written reset/busy sequences.

module tb_lsu_mem_ctrl;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_req_if rq();
    lsu_mem_if mm();

    lsu_mem_ctrl #(.MAX_WAIT(MAXW)) dut (.clk(clk), .rst_n(rst_n), .req(rq), .mem(mm));

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          waits;
        bit          poke;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        st;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } rsp_t;

    acc_t        acc_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] rd_q[$];
    int          wait_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // memory responder: checks each new access, acks after its configured wait
    initial begin
        bit   in_acc;
        int   wcnt;
        int   cur_wait;
        acc_t e;
        in_acc = 0; wcnt = 0; cur_wait = 0;
        mm.mem_ack = 1'b0;
        mm.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mm.mem_req) begin
                if (!in_acc) begin
                    in_acc = 1; wcnt = 0;
                    cur_wait = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
                    if (acc_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_access: got addr %h required none", mm.mem_addr);
                    end else begin
                        e = acc_q.pop_front();
                        check("mem_addr", mm.mem_addr, e.addr);
                        check("mem_we", {28'h0, mm.mem_we}, {28'h0, e.we});
                        if (e.st) check("mem_wdata", mm.mem_wdata, e.wdata);
                    end
                end
                if (wcnt >= cur_wait) begin
                    mm.mem_ack = 1'b1;
                    mm.mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hBAD0BAD0;
                    in_acc = 0;
                end else begin
                    mm.mem_ack = 1'b0;
                    mm.mem_rdata = 32'h0;
                    wcnt++;
                end
            end else begin
                mm.mem_ack = 1'b0;
                in_acc = 0;
            end
        end
    end

    // response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rq.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rsp: got rdata %h err %0d required none", rq.rsp_rdata, rq.rsp_err);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_rdata", rq.rsp_rdata, r.rdata);
                    check("rsp_err", rq.rsp_err, r.err);
                    check("rsp_latency", cyc - r.acc + 1, r.lat);
                end
            end
        end
    end

    // byte-by-byte model of the expected memory accesses
    task automatic push_model(input vec_t v);
        int   n, off, nacc, lane;
        acc_t a [2];
        logic [31:0] base;
        if (v.size == 2'b11) return;
        n    = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
        off  = int'(v.addr[1:0]);
        base = {v.addr[31:2], 2'b00};
        nacc = (off + n > 4) ? 2 : 1;
        for (int k = 0; k < 2; k++) begin
            a[k].addr  = base + 32'(4 * k);
            a[k].we    = 4'b0000;
            a[k].wdata = 32'h0;
            a[k].st    = v.we;
        end
        for (int i = 0; i < n; i++) begin
            lane = off + i;
            if (v.we) begin
                a[lane / 4].we[lane % 4] = 1'b1;
                a[lane / 4].wdata[8 * (lane % 4) +: 8] = v.wdata[8 * i +: 8];
            end
        end
        if (v.waits >= MAXW) nacc = 1;
        for (int k = 0; k < nacc; k++) begin
            acc_q.push_back(a[k]);
            wait_q.push_back(v.waits);
        end
        rd_q.push_back(v.rd0);
        rd_q.push_back(v.rd1);
    endtask

    task automatic drive_req(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        while (!rq.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before", rq.req_ready, 1'b1);
        rq.req_we       = v.we;
        rq.req_size     = v.size;
        rq.req_unsigned = v.uns;
        rq.req_addr     = v.addr;
        rq.req_wdata    = v.wdata;
        rq.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        rsp_t r;
        int   n;
        push_model(v);
        drive_req(v);
        r.acc = cyc; r.rdata = v.exp_rdata; r.err = v.exp_err; r.lat = v.exp_lat;
        rsp_q.push_back(r);
        if (v.poke) begin
            @(negedge clk);
            check("busy_poke", rq.busy, 1'b1);
            rq.req_valid = 1'b1;
            rq.req_we    = 1'b0;
            rq.req_size  = 2'b10;
            rq.req_addr  = 32'h0000_0F00;
            @(negedge clk);
            @(negedge clk);
            rq.req_valid = 1'b0;
        end
        n = 0;
        while (rsp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: got no response required one (vec %0d)", idx);
            rsp_q.delete();
        end
        @(negedge clk);
        check("rsp_pulse", rq.rsp_valid, 1'b0);
        check("ready_after", rq.req_ready, 1'b1);
        check("busy_after", rq.busy, 1'b0);
        check("mem_req_idle", mm.mem_req, 1'b0);
        check("acc_q_empty", acc_q.size(), 0);
        wait_q.delete();
        rd_q.delete();
        $display("vec %0d: we=%0d size=%0d addr=%h exp_rdata=%h exp_err=%0d", idx, v.we, v.size, v.addr, v.exp_rdata, v.exp_err);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rd0, input logic [31:0] rd1, input int waits,
                                input bit poke, input logic [31:0] er, input logic ee, input int lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rd0 = rd0; v.rd1 = rd1; v.waits = waits; v.poke = poke;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        vec_t v;
        vecs[0]  = mk(0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 32'hDEADBEEF, 0, 2);
        vecs[1]  = mk(0, 2'b00, 0, 32'h0000_0103, 32'h0, 32'h80112233, 32'h0, 0, 0, 32'hFFFFFF80, 0, 2);
        vecs[2]  = mk(0, 2'b00, 1, 32'h0000_0103, 32'h0, 32'h80112233, 32'h0, 0, 0, 32'h00000080, 0, 2);
        vecs[3]  = mk(1, 2'b01, 0, 32'h0000_0203, 32'h0000ABCD, 32'h0, 32'h0, 0, 0, 32'h0, 0, 3);
        vecs[4]  = mk(0, 2'b10, 0, 32'hFFFF_FFFE, 32'h0, 32'h11223344, 32'h55667788, 0, 0, 32'h77881122, 0, 3);
        vecs[5]  = mk(0, 2'b01, 0, 32'h0000_0002, 32'h0, 32'h80011234, 32'h0, 0, 0, 32'hFFFF8001, 0, 2);
        vecs[6]  = mk(0, 2'b01, 1, 32'h0000_0001, 32'h0, 32'h12F0E0AB, 32'h0, 0, 0, 32'h0000F0E0, 0, 2);
        vecs[7]  = mk(0, 2'b01, 0, 32'h0000_0001, 32'h0, 32'h12F0E0AB, 32'h0, 0, 0, 32'hFFFFF0E0, 0, 2);
        vecs[8]  = mk(1, 2'b10, 0, 32'h0000_0040, 32'h12345678, 32'h0, 32'h0, 2, 1, 32'h0, 0, 4);
        vecs[9]  = mk(1, 2'b00, 0, 32'h0000_0081, 32'hAABBCCEF, 32'h0, 32'h0, 0, 0, 32'h0, 0, 2);
        vecs[10] = mk(0, 2'b10, 0, 32'h0000_0031, 32'h0, 32'hAABBCCDD, 32'h11223344, 1, 0, 32'h44AABBCC, 0, 5);
        vecs[11] = mk(0, 2'b11, 0, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1);
        vecs[12] = mk(0, 2'b10, 0, 32'h0000_0500, 32'h0, 32'h0, 32'h0, 1000, 0, 32'h0, 1, 5);
        vecs[13] = mk(0, 2'b10, 1, 32'h0000_0008, 32'h0, 32'h80000001, 32'h0, 0, 0, 32'h80000001, 0, 2);
        vecs[14] = mk(0, 2'b00, 0, 32'h0000_0000, 32'h0, 32'h0000007F, 32'h0, 3, 0, 32'h0000007F, 0, 5);
        vecs[15] = mk(1, 2'b00, 0, 32'h0000_0007, 32'hFFFFFF11, 32'h0, 32'h0, 0, 0, 32'h0, 0, 2);

        rq.req_valid = 1'b0; rq.req_we = 1'b0; rq.req_size = 2'b00;
        rq.req_unsigned = 1'b0; rq.req_addr = 32'h0; rq.req_wdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", rq.req_ready, 1'b1);
        check("rst_busy", rq.busy, 1'b0);
        check("rst_rsp_valid", rq.rsp_valid, 1'b0);
        check("rst_rsp_rdata", rq.rsp_rdata, 32'h0);
        check("rst_rsp_err", rq.rsp_err, 1'b0);
        check("rst_mem_req", mm.mem_req, 1'b0);
        check("rst_mem_addr", mm.mem_addr, 32'h0);
        check("rst_mem_we", {28'h0, mm.mem_we}, 32'h0);
        check("rst_mem_wdata", mm.mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // reset asserted while the second half of a split load is stalled
        v = mk(0, 2'b10, 0, 32'h0000_01FE, 32'h0, 32'h01020304, 32'h0, 0, 0, 32'h0, 0, 0);
        push_model(v);
        wait_q.delete();
        wait_q.push_back(0);
        wait_q.push_back(1000);
        drive_req(v);
        @(negedge clk);
        @(negedge clk);
        check("acc1_mem_req", mm.mem_req, 1'b1);
        check("acc1_mem_addr", mm.mem_addr, 32'h0000_0200);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", mm.mem_req, 1'b0);
        check("arst_busy", rq.busy, 1'b0);
        check("arst_rsp_valid", rq.rsp_valid, 1'b0);
        check("arst_req_ready", rq.req_ready, 1'b1);
        acc_q.delete(); rd_q.delete(); wait_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        $display("seq reset_in_acc1: reset applied during split load");
        run_vec(16, mk(0, 2'b10, 0, 32'h0000_0300, 32'h0, 32'hCAFEF00D, 32'h0, 0, 0, 32'hCAFEF00D, 0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
